// File: rtl/as_gpio_port.sv
// Memory-mapped GPIO port: OUT/DIR/IN/STAT registers behind a single-beat bus,
// tri-state pin drive, 2-flop input synchroniser with change detection, cs_o strobe.
module as_gpio_port #(
    parameter int NR_GPIOS   = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    inout  wire  [NR_GPIOS-1:0]   gpio_io,
    output logic                  cs_o
);

    localparam logic [ADDR_WIDTH-1:0] OFF_OUT  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OFF_DIR  = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] OFF_IN   = ADDR_WIDTH'(16);
    localparam logic [ADDR_WIDTH-1:0] OFF_STAT = ADDR_WIDTH'(24);

    logic [NR_GPIOS-1:0] out_bits;
    logic [NR_GPIOS-1:0] dir_bits;
    logic [NR_GPIOS-1:0] stat_bits;
    logic [NR_GPIOS-1:0] sync_p0;
    logic [NR_GPIOS-1:0] sync_p1;
    logic [NR_GPIOS-1:0] prev_p2;

    logic                sel_out, sel_dir, sel_in, sel_stat;
    logic                bad, rd_ok, wr_out, wr_dir, wr_stat;
    logic [NR_GPIOS-1:0] rd_val, stat_set, stat_clr, stat_next;

    // Only the low NR_GPIOS bits of the write bus carry register content.
    logic unused_wdata;
    assign unused_wdata = ^wdata_i[DATA_WIDTH-1:NR_GPIOS];

    always_comb begin
        sel_out  = (addr_i == OFF_OUT);
        sel_dir  = (addr_i == OFF_DIR);
        sel_in   = (addr_i == OFF_IN);
        sel_stat = (addr_i == OFF_STAT);
        bad      = !(sel_out || sel_dir || sel_stat || (sel_in && !we_i));

        wr_out   = req_i && we_i && sel_out;
        wr_dir   = req_i && we_i && sel_dir;
        wr_stat  = req_i && we_i && sel_stat;
        rd_ok    = req_i && !we_i && !bad;

        rd_val = '0;
        if (sel_out)  rd_val = out_bits;
        if (sel_dir)  rd_val = dir_bits;
        if (sel_in)   rd_val = sync_p1;
        if (sel_stat) rd_val = stat_bits;

        // A change detected in the same cycle as a clear keeps the flag set.
        stat_set  = sync_p1 ^ prev_p2;
        stat_clr  = wr_stat ? wdata_i[NR_GPIOS-1:0] : '0;
        stat_next = (stat_bits & ~stat_clr) | stat_set;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            cs_o      <= 1'b0;
            rdata_o   <= '0;
            out_bits  <= '0;
            dir_bits  <= '0;
            stat_bits <= '0;
            sync_p0   <= '0;
            sync_p1   <= '0;
            prev_p2   <= '0;
        end else begin
            ack_o   <= req_i;
            err_o   <= req_i && bad;
            cs_o    <= wr_out;
            rdata_o <= rd_ok ? DATA_WIDTH'(rd_val) : '0;
            if (wr_out) out_bits <= wdata_i[NR_GPIOS-1:0];
            if (wr_dir) dir_bits <= wdata_i[NR_GPIOS-1:0];
            // Pin sample -> synchronised IN -> previous sample for edge detect
            sync_p0   <= gpio_io;
            sync_p1   <= sync_p0;
            prev_p2   <= sync_p1;
            stat_bits <= stat_next;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NR_GPIOS; i++) begin : g_pin
            assign gpio_io[i] = dir_bits[i] ? out_bits[i] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_as_gpio_port.sv
// Scoreboard bench for as_gpio_port: expected responses are queued at request
// time and compared against each ack_o on the falling clock edge.
module tb_as_gpio_port;

    localparam int NG = 8;
    localparam int AW = 5;
    localparam int DW = 64;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic          ack, err, cs;
    logic [DW-1:0] rdata;
    wire  [NG-1:0] gpio;

    logic [NG-1:0] tb_en  = '1;
    logic [NG-1:0] tb_val = '0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            at;
        logic [DW-1:0] rdata;
        logic          err;
        logic          cs;
        logic [NG-1:0] pins;
    } exp_t;

    exp_t sb[$];

    generate
        for (genvar i = 0; i < NG; i++) begin : g_drv
            assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
        end
    endgenerate

    as_gpio_port #(
        .NR_GPIOS  (NG),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .req_i  (req),
        .we_i   (we),
        .addr_i (addr),
        .wdata_i(wdata),
        .ack_o  (ack),
        .err_o  (err),
        .rdata_o(rdata),
        .gpio_io(gpio),
        .cs_o   (cs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", DW'(ack), '0);
                end else begin
                    e = sb.pop_front();
                    check("ack_cycle", DW'(cyc), DW'(e.at));
                    check("rdata", rdata, e.rdata);
                    check("err", DW'(err), DW'(e.err));
                    check("cs", DW'(cs), DW'(e.cs));
                    if (e.cs) check("pins_at_cs", DW'(gpio), DW'(e.pins));
                end
            end else begin
                if (cs || err) check("idle_strobes", DW'({cs, err}), '0);
                if (rdata != '0) check("idle_rdata", rdata, '0);
            end
        end
    end

    task automatic bus_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rd, input logic exp_err,
                          input logic exp_cs, input logic [NG-1:0] exp_pins);
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        sb.push_back('{at: cyc + 1, rdata: exp_rd, err: exp_err, cs: exp_cs, pins: exp_pins});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic exp_err, input logic exp_cs, input logic [NG-1:0] exp_pins);
        bus_op(1'b1, a, d, '0, exp_err, exp_cs, exp_pins);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp_rd, input logic exp_err);
        bus_op(1'b0, a, '0, exp_rd, exp_err, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0;
            we  = 1'b0;
        end
    endtask

    initial begin
        // Reset held for 10 clocks with the bench holding the pins low
        repeat (10) @(posedge clk);
        #1;
        check("rst_ack", DW'(ack), '0);
        check("rst_cs", DW'(cs), '0);
        check("rst_err", DW'(err), '0);
        check("rst_rdata", rdata, '0);
        check("rst_pins", DW'(gpio), '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        rd(5'h00, 64'h0, 1'b0);
        rd(5'h08, 64'h0, 1'b0);
        rd(5'h18, 64'h0, 1'b0);
        rd(5'h10, 64'h0, 1'b0);

        // Drive and strobe
        wr(5'h08, 64'hFF, 1'b0, 1'b0, 8'h00);
        idle(1);
        tb_en = '0;
        wr(5'h00, 64'h04, 1'b0, 1'b1, 8'h04);
        wr(5'h00, 64'h01, 1'b0, 1'b1, 8'h01);
        idle(6);
        rd(5'h00, 64'h01, 1'b0);
        rd(5'h08, 64'hFF, 1'b0);
        rd(5'h18, 64'h05, 1'b0);
        rd(5'h10, 64'h01, 1'b0);
        wr(5'h00, 64'h00, 1'b0, 1'b1, 8'h00);
        idle(5);
        wr(5'h18, 64'hFF, 1'b0, 1'b0, 8'h00);
        rd(5'h18, 64'h00, 1'b0);

        // Input synchroniser
        idle(1);
        tb_val = 8'h00;
        tb_en  = '1;
        wr(5'h08, 64'h00, 1'b0, 1'b0, 8'h00);
        idle(4);
        tb_val = 8'h5A;
        rd(5'h10, 64'h00, 1'b0);
        idle(1);
        rd(5'h10, 64'h5A, 1'b0);
        rd(5'h18, 64'h5A, 1'b0);
        idle(4);

        // STAT clear racing a new change on bit 1
        tb_val = 8'h58;
        idle(1);
        wr(5'h18, 64'h0A, 1'b0, 1'b0, 8'h00);
        rd(5'h18, 64'h52, 1'b0);
        idle(3);

        // Error path
        wr(5'h1C, '1, 1'b1, 1'b0, 8'h00);
        rd(5'h1C, 64'h0, 1'b1);
        wr(5'h10, '1, 1'b1, 1'b0, 8'h00);
        rd(5'h04, 64'h0, 1'b1);
        rd(5'h00, 64'h00, 1'b0);
        rd(5'h08, 64'h00, 1'b0);
        rd(5'h18, 64'h52, 1'b0);
        rd(5'h10, 64'h58, 1'b0);
        idle(2);

        // Reset while a write to OUT is being presented
        wr(5'h00, 64'h58, 1'b0, 1'b1, 8'h58);
        wr(5'h08, 64'hFF, 1'b0, 1'b0, 8'h00);
        idle(1);
        tb_en = '0;
        idle(1);
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 5'h00;
        wdata = 64'h33;
        #4;
        rst_n = 1'b0;
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
        check("midrst_ack", DW'(ack), '0);
        check("midrst_cs", DW'(cs), '0);
        repeat (2) @(negedge clk);
        tb_val = 8'h00;
        tb_en  = '1;
        #1;
        check("midrst_pins", DW'(gpio), '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        rd(5'h00, 64'h00, 1'b0);
        rd(5'h08, 64'h00, 1'b0);
        idle(4);

        check("pending_acks", DW'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
